// File: rtl/buffer_write_ctrl_if.sv
// buffer_write_ctrl_if: sample-in / buffer-write-out bundle; BUFF_OVR_CNT_EN adds ovr_cnt_o
interface buffer_write_ctrl_if #(
    parameter int DATA_BITS = 16,
    parameter int ADDR_BITS = 10
`ifdef BUFF_OVR_CNT_EN
    , parameter int OVR_CNT_BITS = 16
`endif
);
    logic                 en_i;
    logic                 smp_valid_i;
    logic [DATA_BITS-1:0] smp_data_i;
    logic                 rd_busy_i;
    logic                 buff_sel_o;
    logic [ADDR_BITS-1:0] buff_waddr_o;
    logic [DATA_BITS-1:0] buff_wdata_o;
    logic                 buff_wen_o;
    logic                 frame_rdy_o;
    logic                 overrun_o;
`ifdef BUFF_OVR_CNT_EN
    logic [OVR_CNT_BITS-1:0] ovr_cnt_o;
`endif
    modport slave (
        input  en_i, smp_valid_i, smp_data_i, rd_busy_i,
        output buff_sel_o, buff_waddr_o, buff_wdata_o, buff_wen_o, frame_rdy_o, overrun_o
`ifdef BUFF_OVR_CNT_EN
        , output ovr_cnt_o
`endif
    );
    modport master (
        output en_i, smp_valid_i, smp_data_i, rd_busy_i,
        input  buff_sel_o, buff_waddr_o, buff_wdata_o, buff_wen_o, frame_rdy_o, overrun_o
`ifdef BUFF_OVR_CNT_EN
        , input ovr_cnt_o
`endif
    );
endinterface

// File: rtl/buffer_write_ctrl.sv
// buffer_write_ctrl: ping-pong buffer write stage with bank swap and overrun tracking; BUFF_OVR_CNT_EN adds ovr_cnt_o
module buffer_write_ctrl #(
    parameter int DATA_BITS = 16,
    parameter int ADDR_BITS = 10
`ifdef BUFF_OVR_CNT_EN
    , parameter int OVR_CNT_BITS = 16
`endif
) (
    input logic               clk1,
    input logic               rst,
    buffer_write_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, SWAP, HOLD} state_t;
    state_t               state;
    logic [ADDR_BITS:0]   cnt;
    logic                 sel, wen, frame_rdy, overrun, drop;
    logic [ADDR_BITS-1:0] waddr;
    logic [DATA_BITS-1:0] wdata;
    assign drop = bus.en_i && bus.smp_valid_i && (state == SWAP || state == HOLD);
`ifdef BUFF_OVR_CNT_EN
    logic [OVR_CNT_BITS-1:0] ovr_cnt;
    always_ff @(posedge clk1)
        if (rst || (state == IDLE && bus.en_i)) ovr_cnt <= '0;
        else if (drop && !(&ovr_cnt)) ovr_cnt <= ovr_cnt + 1'b1;
    assign bus.ovr_cnt_o = ovr_cnt;
`endif
    always_ff @(posedge clk1) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sel       <= 1'b0;
            wen       <= 1'b0;
            frame_rdy <= 1'b0;
            overrun   <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
        end else begin
            wen       <= 1'b0;
            frame_rdy <= 1'b0;
            if (drop) overrun <= 1'b1;
            if (state != IDLE && !bus.en_i) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.en_i) begin
                        state   <= FILL;
                        cnt     <= '0;
                        overrun <= 1'b0;
                    end
                    FILL: if (bus.smp_valid_i) begin
                        waddr <= cnt[ADDR_BITS-1:0];
                        wdata <= bus.smp_data_i;
                        wen   <= 1'b1;
                        cnt   <= cnt + 1'b1;
                        if (cnt == {1'b0, {ADDR_BITS{1'b1}}}) state <= bus.rd_busy_i ? HOLD : SWAP;
                    end
                    SWAP: begin
                        sel       <= ~sel;
                        frame_rdy <= 1'b1;
                        cnt       <= '0;
                        state     <= FILL;
                    end
                    HOLD: if (!bus.rd_busy_i) state <= SWAP;
                    default: state <= IDLE;
                endcase
            end
        end
    end
    assign bus.buff_sel_o   = sel;
    assign bus.buff_waddr_o = waddr;
    assign bus.buff_wdata_o = wdata;
    assign bus.buff_wen_o   = wen;
    assign bus.frame_rdy_o  = frame_rdy;
    assign bus.overrun_o    = overrun;
endmodule
